regfile: RTL

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_scoreboard.sv | 53 +++++
 rtl/regfile.sv | 117 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
//============================================================================
// Module      : regfile_pkg
// Description : Shared core constants for the pipeline stages: data word
//               width, register-number width, register count, and a helper
//               that turns a register-number width into a register count.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//============================================================================
package regfile_pkg;

    localparam int c_WORD     = 32;
    localparam int c_W_RD     = 5;

    // Number of architectural registers addressed by a W_RD-bit number.
    function automatic int reg_count(input int w_rd);
        return 2 ** w_rd;
    endfunction

    localparam int c_NUM_REGS = reg_count(c_W_RD);

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
//============================================================================
// Module      : scoreboard
// Description : Per-register busy bits. A reserve sets a bit, a writeback
//               clears it; when both target the same register in one cycle
//               the reserve wins. Register 0 is never busy.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               set_i/set_num_i  - reserve (mark busy) request
//               clr_i/clr_num_i  - writeback (clear busy) request
//               rs1_num_i/rs2_num_i   - source register numbers to look up
//               rs1_busy_o/rs2_busy_o - current busy bits of the sources
// Revision    : 1.0 - initial release
//============================================================================
module scoreboard
    import regfile_pkg::*;
#(
    parameter int W_RD = c_W_RD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_i,
    input  logic [W_RD-1:0] set_num_i,
    input  logic            clr_i,
    input  logic [W_RD-1:0] clr_num_i,
    input  logic [W_RD-1:0] rs1_num_i,
    input  logic [W_RD-1:0] rs2_num_i,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o
);

    localparam int c_REGS = reg_count(W_RD);

    logic [c_REGS-1:0] r_busy;
    logic [c_REGS-1:0] w_busy_nxt;

    // Clear first, then set, so a same-cycle reserve overrides the writeback.
    always_comb begin
        w_busy_nxt = r_busy;
        if (clr_i) w_busy_nxt[clr_num_i] = 1'b0;
        if (set_i) w_busy_nxt[set_num_i] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    assign rs1_busy_o = r_busy[rs1_num_i];
    assign rs2_busy_o = r_busy[rs2_num_i];

endmodule : scoreboard
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
//============================================================================
// Module      : regfile
// Description : Two-read, one-write register file with a busy-bit
//               scoreboard. Register 0 reads as zero. Reads stall while a
//               source is pending; accepted reads return registered data
//               one cycle later.
// Config      : REGFILE_BYPASS_EN - forward same-cycle writeback data into
//               the read and let a busy source being written back not stall.
// Ports       : clk, rst                     - clock, sync active-high reset
//               wb_i, wbr_num_i, wb_data_i   - writeback port
//               rd_v_i, rs1_num_i, rs2_num_i - read request from decode
//               rsv_i, rsv_num_i             - reserve destination on issue
//               stall_o                      - read not accepted (comb.)
//               v_o, rs1_data_o, rs2_data_o  - registered read result
// Revision    : 1.0 - initial release
//============================================================================
module regfile
    import regfile_pkg::*;
#(
    parameter int WORD = c_WORD,
    parameter int W_RD = c_W_RD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_i,
    input  logic [W_RD-1:0] wbr_num_i,
    input  logic [WORD-1:0] wb_data_i,
    input  logic            rd_v_i,
    input  logic [W_RD-1:0] rs1_num_i,
    input  logic [W_RD-1:0] rs2_num_i,
    input  logic            rsv_i,
    input  logic [W_RD-1:0] rsv_num_i,
    output logic            stall_o,
    output logic            v_o,
    output logic [WORD-1:0] rs1_data_o,
    output logic [WORD-1:0] rs2_data_o
);

    localparam int c_REGS = reg_count(W_RD);

    logic [WORD-1:0] r_regs [c_REGS];
    logic            r_v;
    logic [WORD-1:0] r_rs1_data;
    logic [WORD-1:0] r_rs2_data;

    logic            w_rs1_busy;
    logic            w_rs2_busy;
    logic            w_rs1_hit;
    logic            w_rs2_hit;
    logic            w_accept;
    logic [WORD-1:0] w_rs1_val;
    logic [WORD-1:0] w_rs2_val;

    scoreboard #(
        .W_RD (W_RD)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_i      (w_accept & rsv_i),
        .set_num_i  (rsv_num_i),
        .clr_i      (wb_i),
        .clr_num_i  (wbr_num_i),
        .rs1_num_i  (rs1_num_i),
        .rs2_num_i  (rs2_num_i),
        .rs1_busy_o (w_rs1_busy),
        .rs2_busy_o (w_rs2_busy)
    );

    // A "hit" is a writeback landing on a source this cycle; only the
    // forwarding build may use it to release a stall.
`ifdef REGFILE_BYPASS_EN
    assign w_rs1_hit = wb_i && (wbr_num_i == rs1_num_i) && (rs1_num_i != '0);
    assign w_rs2_hit = wb_i && (wbr_num_i == rs2_num_i) && (rs2_num_i != '0);
`else
    assign w_rs1_hit = 1'b0;
    assign w_rs2_hit = 1'b0;
`endif

    assign stall_o  = rd_v_i && ((w_rs1_busy && !w_rs1_hit) ||
                                 (w_rs2_busy && !w_rs2_hit));
    assign w_accept = rd_v_i && !stall_o;

    always_comb begin
        w_rs1_val = (rs1_num_i == '0) ? '0 : r_regs[rs1_num_i];
        w_rs2_val = (rs2_num_i == '0) ? '0 : r_regs[rs2_num_i];
        if (w_rs1_hit) w_rs1_val = wb_data_i;
        if (w_rs2_hit) w_rs2_val = wb_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_REGS; i++) r_regs[i] <= '0;
        end else if (wb_i && (wbr_num_i != '0)) begin
            r_regs[wbr_num_i] <= wb_data_i;
        end
    end

    // Read data is forced to zero whenever no read was accepted.
    always_ff @(posedge clk) begin
        if (rst || !w_accept) begin
            r_v        <= 1'b0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else begin
            r_v        <= 1'b1;
            r_rs1_data <= w_rs1_val;
            r_rs2_data <= w_rs2_val;
        end
    end

    assign v_o        = r_v;
    assign rs1_data_o = r_rs1_data;
    assign rs2_data_o = r_rs2_data;

endmodule : regfile
`default_nettype wire
